uart_tx_fifo: RTL and testbench

// Transmit buffer directly upstream of the UART transmitter. The CPU pushes bytes
// at bus speed. The block drains them one at a time into the UART's
// tx_data/tx_strobe interface, paced by the UART's tx_busy.

---
 rtl/uart_tx_fifo.sv | 99 +++++++++
 tb/tb_uart_tx_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU and the UART transmitter: buffers pushes and
// launches one byte per tx_strobe pulse, paced by the UART's tx_busy.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  raw_clk,
    input  logic                  reset_n,
    input  logic [7:0]            wr_data,
    input  logic                  wr_strobe,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  overflow_clear,
    output logic [7:0]            uart_tx_data,
    output logic                  uart_tx_strobe,
    input  logic                  uart_tx_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  drop;
    logic                  launch;

    assign full  = (count == COUNT_FULL);
    assign empty = (count == '0);
    assign push  = wr_strobe && !full;
    assign drop  = wr_strobe && full;

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    launch     = 1'b1;
                    state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (uart_tx_busy) state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge raw_clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // rd_ptr moves at launch; count drops at the end of the strobe cycle, so a
    // push in that cycle still sees full and is dropped.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overflow       <= 1'b0;
            uart_tx_data   <= 8'h00;
            uart_tx_strobe <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_ONE;
            if (launch) rd_ptr <= rd_ptr + PTR_ONE;

            if (push && !uart_tx_strobe)      count <= count + COUNT_ONE;
            else if (!push && uart_tx_strobe) count <= count - COUNT_ONE;

            if (drop)                overflow <= 1'b1;
            else if (overflow_clear) overflow <= 1'b0;

            uart_tx_strobe <= launch;
            if (launch) uart_tx_data <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo with a queue-based FIFO model, a simple
// UART serializer model, and directed latency/boundary scenarios.
module tb_uart_tx_fifo;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int BIT_CYC    = 2;
    localparam int FRAME_CYC  = 10 * BIT_CYC;

    logic                raw_clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [7:0]          wr_data = 8'h00;
    logic                wr_strobe = 1'b0;
    logic                overflow_clear = 1'b0;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                uart_tx_strobe;
    logic [DEPTH_LOG2:0] count;
    logic [7:0]          uart_tx_data;
    logic                uart_tx_busy;
    logic                hold_busy = 1'b0;

    always #5 raw_clk = ~raw_clk;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .raw_clk        (raw_clk),
        .reset_n        (reset_n),
        .wr_data        (wr_data),
        .wr_strobe      (wr_strobe),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .overflow_clear (overflow_clear),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_strobe (uart_tx_strobe),
        .uart_tx_busy   (uart_tx_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // UART model: busy rises the cycle after the strobe and lasts one frame
    int         ucnt = 0;
    logic [9:0] ushift = '1;
    logic [9:0] rx_bits = '1;
    logic [9:0] frame = '1;
    int         frames_done = 0;
    logic       strobe_s = 1'b0;
    logic [7:0] data_s = 8'h00;
    logic       tx_pin;

    assign uart_tx_busy = (ucnt != 0) || hold_busy;
    assign tx_pin = (ucnt != 0) ? ushift[(FRAME_CYC - ucnt) / BIT_CYC] : 1'b1;

    always @(posedge raw_clk) begin
        if (strobe_s) begin
            ushift <= {1'b1, data_s, 1'b0};
            ucnt   <= FRAME_CYC;
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) begin
                frame       <= rx_bits;
                frames_done <= frames_done + 1;
            end
        end
    end

    always @(negedge raw_clk) begin
        if (ucnt != 0) rx_bits[(FRAME_CYC - ucnt) / BIT_CYC] <= tx_pin;
    end

    // FIFO model: queue of held bytes, count lags a launch by one cycle
    logic [7:0] hq[$];
    logic [7:0] out_log[$];
    int         exp_count = 0;
    logic       exp_ovf = 1'b0;
    logic [7:0] last_data = 8'h00;

    always @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            hq.delete();
            exp_count = 0;
            exp_ovf   = 1'b0;
            last_data = 8'h00;
            strobe_s  = 1'b0;
        end else begin
            int nc;
            nc = exp_count;
            if (wr_strobe && exp_count == DEPTH) exp_ovf = 1'b1;
            else if (overflow_clear)             exp_ovf = 1'b0;
            if (wr_strobe && exp_count != DEPTH) begin
                hq.push_back(wr_data);
                nc++;
            end
            if (strobe_s) nc--;
            exp_count = nc;
        end
    end

    logic last_busy = 1'b0;
    logic last_strobe = 1'b0;

    always @(negedge raw_clk) begin
        chk("count", int'(count), exp_count);
        chk("full", int'(full), int'(exp_count == DEPTH));
        chk("empty", int'(empty), int'(exp_count == 0));
        chk("overflow", int'(overflow), int'(exp_ovf));
        if (uart_tx_strobe) begin
            chk("strobe_busy_low", int'(last_busy), 0);
            chk("strobe_single", int'(last_strobe), 0);
            chk("strobe_has_byte", int'(hq.size() > 0), 1);
            if (hq.size() > 0) chk("strobe_order", int'(uart_tx_data), int'(hq.pop_front()));
            last_data = uart_tx_data;
            out_log.push_back(uart_tx_data);
        end else begin
            chk("data_held", int'(uart_tx_data), int'(last_data));
        end
        strobe_s    = uart_tx_strobe;
        data_s      = uart_tx_data;
        last_busy   = uart_tx_busy;
        last_strobe = uart_tx_strobe;
    end

    function automatic int log_at(input int i);
        if (i < out_log.size()) return int'(out_log[i]);
        return -1;
    endfunction

    task automatic tick();
        @(posedge raw_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_data   = b;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while ((hq.size() != 0 || exp_count != 0 || ucnt != 0) && n < budget) begin
            tick();
            n++;
        end
        tick();
        chk(name, int'(n < budget), 1);
    endtask

    task automatic wait_frame(input string name, input int fd, input int budget);
        int n;
        n = 0;
        while (frames_done == fd && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(n < budget), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int fd;
        int n;
        logic [7:0] bytes_a [16];
        logic [7:0] bytes_b [16];

        repeat (3) @(posedge raw_clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_strobe", int'(uart_tx_strobe), 0);
        chk("rst_data", int'(uart_tx_data), 0);
        reset_n = 1'b1;
        tick();

        // single byte latency and serial frame
        fd = frames_done;
        s0 = out_log.size();
        push(8'h41);
        chk("t1_count_n1", int'(count), 1);
        chk("t1_strobe_n1", int'(uart_tx_strobe), 0);
        tick();
        chk("t1_strobe_n2", int'(uart_tx_strobe), 1);
        chk("t1_data_n2", int'(uart_tx_data), 'h41);
        tick();
        chk("t1_count_n3", int'(count), 0);
        chk("t1_strobe_n3", int'(uart_tx_strobe), 0);
        wait_frame("t1_frame_done", fd, 100);
        chk("t1_frame", int'(frame), int'(10'b1_0100_0001_0));
        chk("t1_one_strobe", out_log.size() - s0, 1);
        chk("t1_empty", int'(empty), 1);

        // three queued bytes
        wait_drained("t2_idle", 200);
        s0 = out_log.size();
        hold_busy = 1'b1;
        push(8'h48);
        push(8'h69);
        push(8'h0A);
        chk("t2_count_peak", int'(count), 3);
        hold_busy = 1'b0;
        wait_drained("t2_drain", 300);
        chk("t2_strobes", out_log.size() - s0, 3);
        chk("t2_b0", log_at(s0), 'h48);
        chk("t2_b1", log_at(s0 + 1), 'h69);
        chk("t2_b2", log_at(s0 + 2), 'h0A);

        // fill to full, drop the 17th; set wins over a simultaneous clear
        s0 = out_log.size();
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t3_full", int'(full), 1);
        chk("t3_count16", int'(count), 16);
        chk("t3_no_ovf_yet", int'(overflow), 0);
        overflow_clear = 1'b1;
        push(8'h10);
        overflow_clear = 1'b0;
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_count_kept", int'(count), 16);
        hold_busy = 1'b0;
        wait_drained("t3_drain", 1000);
        chk("t3_total", out_log.size() - s0, 16);
        for (int i = 0; i < 16; i++) chk("t3_byte", log_at(s0 + i), i);

        // push during the pop cycle of a full FIFO
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        chk("t4_ovf_cleared", int'(overflow), 0);
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
        chk("t4_full", int'(full), 1);
        hold_busy = 1'b0;
        n = 0;
        while (!uart_tx_strobe && n < 20) begin
            tick();
            n++;
        end
        chk("t4_launch", int'(n < 20), 1);
        push(8'hEE);
        chk("t4_count15", int'(count), 15);
        chk("t4_overflow", int'(overflow), 1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        chk("t4_ovf_clear", int'(overflow), 0);
        wait_drained("t4_drain", 1000);

        // reset mid-transfer with five bytes queued
        fd = frames_done;
        s0 = out_log.size();
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
        chk("t5_count5", int'(count), 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_count", int'(count), 0);
        chk("t5_empty", int'(empty), 1);
        chk("t5_strobe", int'(uart_tx_strobe), 0);
        chk("t5_data", int'(uart_tx_data), 0);
        tick();
        tick();
        reset_n = 1'b1;
        wait_frame("t5_frame_done", fd, 100);
        chk("t5_frame", int'(frame), int'({1'b1, 8'hA0, 1'b0}));
        repeat (60) tick();
        chk("t5_no_more_strobes", out_log.size() - s0, 1);

        // wrap: fill, drain, refill
        s0 = out_log.size();
        for (int i = 0; i < 16; i++) bytes_a[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) bytes_b[i] = 8'($urandom_range(0, 255));
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(bytes_a[i]);
        hold_busy = 1'b0;
        wait_drained("t6_drain_a", 1000);
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(bytes_b[i]);
        hold_busy = 1'b0;
        wait_drained("t6_drain_b", 1000);
        for (int i = 0; i < 16; i++) chk("t6_a", log_at(s0 + i), int'(bytes_a[i]));
        for (int i = 0; i < 16; i++) chk("t6_b", log_at(s0 + 16 + i), int'(bytes_b[i]));

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            wr_strobe      = ($urandom_range(0, 99) < 40);
            wr_data        = 8'($urandom_range(0, 255));
            overflow_clear = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) hold_busy = ~hold_busy;
            tick();
        end
        wr_strobe      = 1'b0;
        overflow_clear = 1'b0;
        hold_busy      = 1'b0;
        wait_drained("rand_drain", 2000);
        chk("rand_final_empty", int'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
